// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned FetchAddrW = 10;
  localparam int unsigned FetchDataW = 32;

  // One fetch queue slot: word index plus the instruction read from it.
  typedef struct packed {
    logic [FetchAddrW-1:0] pc;
    logic [FetchDataW-1:0] insn;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, insn} pairs with synchronous flush.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t entry_q [2];
  fetch_entry_t entry_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // Next-state: flush wins, otherwise push and pop update independently.
  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) begin
        entry_d[wr_ptr_q] = push_data_i;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      entry_q  <= entry_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/insn_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one-cycle memory reads, buffers
// returned words in a 2-entry queue and hands them to decode.
module insn_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = FetchAddrW,
  parameter int unsigned DATA_W   = FetchDataW,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_insn,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_vld_q, req_vld_d;
  fetch_state_e      state_q, state_d;

  logic         pop;
  logic         push;
  logic         issue;
  logic [1:0]   count;
  logic [2:0]   occupancy;
  fetch_entry_t push_data;
  fetch_entry_t head;

  assign pop  = out_valid & out_ready;
  // A redirect discards the in-flight read rather than queueing it.
  assign push = req_vld_q & ~redirect_valid;

  // Entries held after this edge if nothing new is issued; issue only when a
  // slot is guaranteed free for the word it will return.
  assign occupancy = {1'b0, count} + {2'b00, req_vld_q} - {2'b00, pop};
  assign issue     = (state_q == StRun) & ~halt & ~redirect_valid & (occupancy < 3'd2);

  // FSM next state and fetch PC / in-flight tracking.
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    req_pc_d  = req_pc_q;
    req_vld_d = 1'b0;
    unique case (state_q)
      StRun:    if (halt)  state_d = StHalted;
      StHalted: if (!halt) state_d = StRun;
      default:  state_d = StRun;
    endcase
    if (redirect_valid) begin
      fpc_d = redirect_pc;
    end else if (issue) begin
      req_vld_d = 1'b1;
      req_pc_d  = fpc_q;
      fpc_d     = fpc_q + ADDR_W'(1);
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      fpc_q     <= ADDR_W'(RESET_PC);
      req_pc_q  <= '0;
      req_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      req_pc_q  <= req_pc_d;
      req_vld_q <= req_vld_d;
    end
  end

  assign push_data = '{pc: req_pc_q, insn: mem_data};

  fetch_queue u_queue (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (count)
  );

  assign mem_addr  = fpc_q;
  assign out_valid = (count != 2'd0);
  assign out_insn  = head.insn;
  assign out_pc    = head.pc;

endmodule
